// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first.
// Optional signed-overflow output ovf_out is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,output logic            ovf_out
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             bw_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   logic             d_bit_d;
   logic             bw_d;
   logic [WIDTH-1:0] res_d;
   logic             last_step;
   logic             accept;

   // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
   always_comb begin
      d_bit_d   = a_q[0] ^ b_q[0] ^ bw_q;
      bw_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
      res_d     = {d_bit_d, res_q[WIDTH-1:1]};
      last_step = (cnt_q == CW'(WIDTH - 1));
      accept    = start && (state_q != RUN);
   end

   // NOTE: operand and shift registers are not reset; they are always reloaded or
   // fully overwritten before their contents reach an output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (accept) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  bw_q    <= borrow_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               bw_q  <= bw_d;
               res_q <= res_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_step) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  diff_q  <= res_d;
                  bout_q  <= bw_d;
`ifdef SERIAL_SUB_OVF_EN
                  // borrow into the sign bit differs from borrow out of it on signed overflow
                  ovf_q   <= bw_q ^ bw_d;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff_out   = diff_q;
   assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf_out    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, back-to-back, reset-abort
// and randomized operations against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff_out;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf_out;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff_out   (diff_out),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,.ovf_out   (ovf_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      vec_t v;
      int   r;
      int   sa;
      int   sb;
      int   rs;
      r  = int'(a) - int'(b) - int'(bin);
      sa = int'($signed(a));
      sb = int'($signed(b));
      rs = sa - sb - int'(bin);
      v.a   = a;
      v.b   = b;
      v.bin = bin;
      v.d   = r[W-1:0];
      v.bo  = (r < 0);
      v.ov  = (rs < -(1 << (W - 1))) || (rs > (1 << (W - 1)) - 1);
      return v;
   endfunction

   task automatic check_result(input string tag, input vec_t v);
      check({tag, "_diff"}, 32'(diff_out), 32'(v.d));
      check({tag, "_borrow"}, 32'(borrow_out), 32'(v.bo));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf_out), 32'(v.ov));
`endif
   endtask

   // Called on a negedge: present operands and raise start for one edge.
   task automatic launch(input vec_t v);
      a_in      = v.a;
      b_in      = v.b;
      borrow_in = v.bin;
      start     = 1'b1;
   endtask

   // Drops start, scrambles inputs, then times busy/done and checks the result.
   task automatic finish_op(input string tag, input vec_t v);
      int n_busy = 0;
      int cyc    = 0;
      @(negedge clk);
      start     = 1'b0;
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      borrow_in = 1'($urandom);
      while (!done && cyc < 4 * W) begin
         if (busy) n_busy++;
         cyc++;
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, 32'(n_busy), 32'(W));
      check({tag, "_latency"}, 32'(cyc), 32'(W));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check_result(tag, v);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold_diff"}, 32'(diff_out), 32'(v.d));
   endtask

   task automatic run_op(input string tag, input vec_t v);
      @(negedge clk);
      launch(v);
      finish_op(tag, v);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v1;
      vec_t v2;

      tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tbl[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
      tbl[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[8] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
      tbl[9] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

      rst       = 1'b1;
      start     = 1'b0;
      a_in      = '0;
      b_in      = '0;
      borrow_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff_out), 32'd0);
      check("reset_borrow", 32'(borrow_out), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_op($sformatf("tbl%0d", i), tbl[i]);

      // Start held high throughout: operands change mid-RUN, back-to-back restart from DONE.
      v1 = model(8'h5A, 8'h3C, 1'b1);
      v2 = model(8'h21, 8'hC4, 1'b0);
      @(negedge clk);
      launch(v1);
      for (int k = 1; k <= 2 * (W + 1); k++) begin
         @(negedge clk);
         if (k == 3) begin
            a_in      = v2.a;
            b_in      = v2.b;
            borrow_in = v2.bin;
         end
         check($sformatf("b2b_done_k%0d", k), 32'(done),
               32'((k == W + 1) || (k == 2 * (W + 1))));
         check($sformatf("b2b_busy_k%0d", k), 32'(busy),
               32'((k != W + 1) && (k != 2 * (W + 1))));
         if (k == W + 1) check_result("b2b_first", v1);
      end
      check_result("b2b_second", v2);
      start = 1'b0;
      @(negedge clk);
      check("b2b_idle_done", 32'(done), 32'd0);
      check("b2b_idle_busy", 32'(busy), 32'd0);

      // Reset in the middle of RUN aborts with no done pulse and clears outputs.
      run_op("pre_rst", model(8'hC3, 8'h14, 1'b0));
      @(negedge clk);
      launch(model(8'h99, 8'h11, 1'b0));
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done_pre", 32'(done), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff_out), 32'd0);
      check("abort_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort_ovf", 32'(ovf_out), 32'd0);
`endif
      @(negedge clk);
      check("abort_no_done_rst", 32'(done), 32'd0);
      rst = 1'b0;
      v1 = model(8'h37, 8'h62, 1'b1);
      launch(v1);
      finish_op("post_rst", v1);

      for (int i = 0; i < 40; i++)
         run_op($sformatf("rnd%0d", i), model(W'($urandom), W'($urandom), 1'($urandom)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction.
REQ-005 SHALL have port a_in  input  WIDTH  minuend, sampled on an accepted start.
REQ-006 SHALL have port b_in  input  WIDTH  subtrahend, sampled on an accepted start.
REQ-007 SHALL have port borrow_in  input  1  initial borrow, sampled on an accepted start.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port diff_out  output  WIDTH  registered result a - b - borrow_in, modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out  output  1  registered final borrow.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on that edge latch a_in, b_in and borrow_in, clear the bit counter, and enter RUN.
REQ-014 SHALL ignore start while in RUN, leaving operands, counter and outputs unchanged.
REQ-015 SHALL process one bit per RUN edge, LSB first, using a full-subtractor cell: d = a ^ b ^ bw; bw' = (~a & b) | (~(a ^ b) & bw).
REQ-016 SHALL shift each d into the result register, MSB end first, so diff_out is bit-aligned after WIDTH steps.
REQ-017 SHALL carry bw' in a single borrow flip-flop between steps.
REQ-018 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; latency from the accepting edge to done high is WIDTH+1 edges.
REQ-019 SHALL assert done only in DONE, for exactly one cycle, then enter IDLE unless start is accepted on that edge.
REQ-020 SHALL update diff_out and borrow_out only on the DONE-entry edge and hold them until the next DONE-entry or reset.
REQ-021 SHALL drive busy high exactly in RUN.
REQ-022 SHALL, on start in DONE, assert done that cycle and enter RUN on the next edge (back-to-back operation).

Reset
REQ-023 SHALL, when rst is high at a clock edge, enter IDLE and clear busy, done, diff_out, borrow_out, the counter and the borrow flip-flop to 0.
REQ-024 SHALL give rst priority over start and abort a RUN in progress without a done pulse.
REQ-025 SHALL, on the first edge after rst falls, accept start normally.

Configuration
REQ-026 SHALL use macro SERIAL_SUB_OVF_EN to select the overflow feature.
REQ-027 With SERIAL_SUB_OVF_EN defined, SHALL add port ovf_out  output  1, meaning two's-complement signed overflow.
REQ-028 With SERIAL_SUB_OVF_EN defined, ovf_out SHALL be computed as the XOR of the borrow into and out of bit WIDTH-1.
REQ-029 With SERIAL_SUB_OVF_EN defined, ovf_out SHALL update with diff_out, hold with it, and reset to 0.
REQ-030 Without SERIAL_SUB_OVF_EN, ovf_out and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover: WIDTH=8, a=0x05, b=0x03, borrow_in=0, start 1 cycle -> busy 8 cycles, done 9th cycle, diff_out=0x02, borrow_out=0.
REQ-032 SHALL cover: a=0x03, b=0x05, borrow_in=0 -> diff_out=0xFE, borrow_out=1.
REQ-033 SHALL cover: a=0x00, b=0x00, borrow_in=1 -> diff_out=0xFF, borrow_out=1.
REQ-034 SHALL cover: start held high throughout, a/b changed mid-RUN -> first result unaffected; second operation starts from the DONE cycle; done pulses every 9 cycles.
REQ-035 SHALL cover: rst asserted at RUN step 4 -> no done pulse; all outputs 0; next start yields a correct result.
REQ-036 SHALL cover, with SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff_out=0x7F, ovf_out=1; a=0x10, b=0x01 -> ovf_out=0.
